// File: rtl/fifo_rd_pkg.sv
// Shared constants and occupancy encoding for the FIFO stream reader.
// FIFO_RD_CNT_EN enables the delivered-word counter in the top.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO pop side plus valid/ready stream side of the reader.
// The master modport is the reader; the slave modport is the FIFO and the downstream sink.
interface fifo_stream_reader_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered buffer; a push lands one cycle later, the head is registered.
// Push into a full buffer is never issued by the caller; push with pop keeps occupancy.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output occ_e              occ,
  output logic [DATA_W-1:0] head_dat
);

  logic [DATA_W-1:0] tail_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      head_dat <= '0;
      tail_dat <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (occ)
            OCC_EMPTY: begin head_dat <= push_dat; occ <= OCC_ONE; end
            OCC_ONE:   begin tail_dat <= push_dat; occ <= OCC_TWO; end
            default:   ;
          endcase
        end
        2'b01: begin
          case (occ)
            OCC_ONE: occ <= OCC_EMPTY;
            OCC_TWO: begin head_dat <= tail_dat; occ <= OCC_ONE; end
            default: ;
          endcase
        end
        2'b11: begin
          // Head leaves while the new word joins behind whatever remains.
          case (occ)
            OCC_ONE: head_dat <= push_dat;
            OCC_TWO: begin head_dat <= tail_dat; tail_dat <= push_dat; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Sync-FIFO to valid/ready stream adapter, 2 cycles pop->m_valid, 1 word/cycle sustained.
// Pops only against buffer credit, so m_ready low stalls at two buffered words; FIFO_RD_CNT_EN adds rd_count.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]     rd_count
`endif
);

  occ_e       occ;
  logic       inflight;
  logic       pop;
  logic       rd_en;
  logic [1:0] used;
  logic [1:0] avail;

  assign pop   = bus.m_valid && bus.m_ready;
  // Credit = avail - used; a same-cycle pop frees a slot for this cycle's request.
  assign used  = 2'(occ) + {1'b0, inflight};
  assign avail = 2'd2 + {1'b0, pop};
  assign rd_en = !rst && !bus.fifo_empty && (used < avail);

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != OCC_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= rd_en;
  end

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat (bus.fifo_data),
    .pop      (pop),
    .occ      (occ),
    .head_dat (bus.m_data)
  );

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)      rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_W'(1);
  end
`endif

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning the FIFO word and stream data width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port fifo_empty, input, 1 bit: the sync FIFO's empty flag.
REQ-005 SHALL have port fifo_rd_en, output, 1 bit: the pop request to the sync FIFO.
REQ-006 SHALL have port fifo_data, input, DATA_W bits: the FIFO's registered data_out, valid the cycle after an accepted pop.
REQ-007 SHALL have port m_valid, output, 1 bit: stream word available.
REQ-008 SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-009 SHALL have port m_data, output, DATA_W bits: stream word, in FIFO order.
REQ-010 SHALL have port rd_count, output, 16 bits: words delivered; present only with FIFO_RD_CNT_EN.

Function
REQ-011 SHALL hold an internal 2-entry ordered buffer; occupancy states: EMPTY (0), ONE (1), TWO (2).
REQ-012 SHALL hold an inflight flag, set the cycle after fifo_rd_en && !fifo_empty, else cleared.
REQ-013 SHALL drive fifo_rd_en = !fifo_empty && credit > 0, credit = 2 - occupancy - inflight + (m_valid && m_ready); this combinational path from m_ready is intended.
REQ-014 SHALL never assert fifo_rd_en while fifo_empty is high.
REQ-015 SHALL capture fifo_data into the buffer tail on every cycle inflight is high, with no word dropped or duplicated.
REQ-016 SHALL drive m_valid = (occupancy != 0) and m_data = the buffer head, both from registers.
REQ-017 SHALL hold m_data stable while m_valid && !m_ready.
REQ-018 SHALL pop the head on m_valid && m_ready; a simultaneous capture and pop SHALL leave occupancy unchanged and preserve order.
REQ-019 SHALL give 2-cycle latency: pop issued in cycle N, m_valid high in cycle N+2.
REQ-020 SHALL sustain 1 word/cycle with m_ready held high and the FIFO non-empty.
REQ-021 SHALL stop issuing pops when m_ready is low, reaching occupancy TWO with inflight low; no overflow SHALL occur.
REQ-022 SHALL make the occupancy transitions EMPTY->ONE on capture, ONE->TWO on capture without pop, TWO->ONE on pop without capture, ONE->EMPTY on pop without capture.

Reset
REQ-023 SHALL on rst clear occupancy to EMPTY, inflight to 0, m_valid to 0, m_data to 0 and rd_count to 0.
REQ-024 SHALL force fifo_rd_en to 0 during any cycle rst is high.
REQ-025 SHALL discard an in-flight word when rst is asserted mid-operation, with no capture in the following cycle.

Configuration
REQ-026 SHALL, with FIFO_RD_CNT_EN defined, increment rd_count on each m_valid && m_ready, wrapping 0xFFFF->0x0000.
REQ-027 SHALL, with FIFO_RD_CNT_EN undefined, omit the rd_count port and its register, with all other behaviour identical.

Structure
REQ-028 SHALL place the DATA_W default, the occupancy state encoding and the counter width constant in shared package fifo_rd_pkg.
REQ-029 SHALL implement the 2-entry ordered buffer as one sub-module, fifo_rd_skid, with the credit/pop control kept in fifo_stream_reader.

Verification
REQ-030 Reset: rst high 2 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0.
REQ-031 Streaming: FIFO holds 3,7,A,F, m_ready=1 -> m_data 3,7,A,F on consecutive cycles, first at pop+2, rd_count=4.
REQ-032 Backpressure: m_ready=0 with 5 words queued -> exactly 2 pops, occupancy TWO, m_data=first word held; m_ready=1 -> all 5 words delivered in order.
REQ-033 Empty boundary: FIFO goes empty after word 9 -> fifo_rd_en never high while fifo_empty=1; m_valid drops after 9 is accepted.
REQ-034 Reset mid-flight: rst asserted the cycle after a pop of 5 -> 5 never appears on m_data; m_valid=0.
REQ-035 Counter wrap: preload 0xFFFF deliveries, then 1 more -> rd_count=0x0000; build without FIFO_RD_CNT_EN has no rd_count port.
